qed_dup_replay_buffer: RTL
==========================

// Module: qed_dup_replay_buffer
// PURPOSE
// - QED instruction cache/replay stage. Sits between fetch and the QED mux, directly upstream of
//   the QED instruction-modify stage.
// - In ORIG mode it passes each fetched instruction through and records it. In DUP mode it
//   replays the recorded sequence, feeding qic_qimux_instruction so the modify stage can
//   remap registers and memory.
// PARAMETERS
// - DEPTH  16  recorded instructions per ORIG/DUP round; power of 2, >=2
// - WIDTH  32  instruction width
// PORTS
// - clk                    in   1      sole clock; all state updates on posedge
// - rst_n                  in   1      synchronous, active-low reset
// - qed_ena                in   1      QED enable; 0 = pure pass-through, nothing recorded
// - stall                  in   1      pipeline stall; freezes all state and outputs
// - ifu_instruction        in   WIDTH  fetched original instruction
// - ifu_vld                in   1      ifu_instruction is valid this cycle
// - exec_dup_req           in   1      request to end ORIG phase and start replay
// - qic_qimux_instruction  out  WIDTH  instruction to QED mux/modify stage (registered)
// - qic_vld                out  1      qic_qimux_instruction valid
// - qed_exec_dup           out  1      1 while output is a replayed instruction (DUP mode)
// - qic_fetch_hold         out  1      1 = fetch must hold PC (DUP mode, or buffer full)
// - qic_count              out  $clog2(DEPTH)+1  instructions recorded this round
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): mode=ORIG, wr_ptr=rd_ptr=count=0, qic_qimux_instruction=NOP
//   (32'h0000_0013), qic_vld=0, qed_exec_dup=0, qic_fetch_hold=0. Mid-replay reset drops the round.
// - stall=1: every register holds, including the outputs; exec_dup_req is ignored that cycle.
// - Latency: one cycle. The output registers load at the posedge after the input/replay read.
// - FSM with two states.
//   ORIG -> DUP when (exec_dup_req | count==DEPTH) & count!=0 & qed_ena & !stall.
//   DUP -> ORIG when the last replay is issued (rd_ptr==count-1 & !stall).
//   On DUP->ORIG, clear wr_ptr, rd_ptr and count.
// - ORIG, ifu_vld & !stall:
//   output <= ifu_instruction, qic_vld <= 1.
//   If qed_ena & count<DEPTH: ram[wr_ptr] <= ifu_instruction, then wr_ptr++ and count++.
// - ORIG, ifu_vld=0: qic_vld <= 0 and output holds NOP.
// - Full: qic_fetch_hold=1 combinationally when count==DEPTH. No write occurs at full; the
//   fetch holds, so no instruction is lost.
// - Simultaneous exec_dup_req & ifu_vld in ORIG: the instruction is passed and recorded first.
//   The transition occurs on the same edge, with count including that instruction.
// - exec_dup_req with count==0: ignored, stays ORIG.
// - DUP, !stall: output <= ram[rd_ptr], qic_vld <= 1, qed_exec_dup <= 1, rd_ptr++.
//   qic_fetch_hold=1 throughout DUP. ifu_instruction is ignored.
// - Replays are in recording order, exactly count instructions.
//   qed_exec_dup drops on the edge after the last replay.
// - qed_ena=0: forced ORIG behaviour with no recording. Deasserting qed_ena during DUP does
//   not abort the replay; the round completes first.
// - Pointers are $clog2(DEPTH) bits and never wrap within a round. count saturates at DEPTH.
// CONFIGURATION
// - QED_IC_NOP_FILTER_EN defined: ORIG instructions equal to NOP (32'h0000_0013) are passed
//   through but not recorded and do not advance count.
// - QED_IC_NOP_FILTER_EN undefined: NOPs are recorded and replayed like any instruction.
// STRUCTURE
// - Package qed_pkg holds:
//   - QED_NOP = 32'h0000_0013
//   - qed_ic_mode_t enum {QIC_ORIG, QIC_DUP}
//   - function qic_ptr_w(DEPTH) = $clog2(DEPTH)
// - Sub-module qed_ic_ram: DEPTH x WIDTH register array; 1 sync write port, 1 async read port;
//   no reset on contents.
// - Top holds the FSM, pointers, count and output registers.
// TESTING
// - Reset then 3 valid instrs A,B,C, then exec_dup_req -> out A,B,C with qed_exec_dup=0;
//   next 3 cycles out A,B,C with qed_exec_dup=1; then ORIG with count=0.
// - DEPTH=16 valid instrs with no request -> qic_fetch_hold=1 at count=16; auto DUP replays all
//   16 in order; hold drops after the last.
// - stall=1 for 2 cycles mid-replay (after the 2nd of 4) -> output frozen; resumes with the 3rd;
//   4 replays total.
// - exec_dup_req at count=0 -> remains ORIG, qed_exec_dup=0, qic_fetch_hold=0.
// - rst_n=0 during DUP at rd_ptr=2 -> next cycle ORIG, count=0, qic_vld=0, output=NOP.
// - With QED_IC_NOP_FILTER_EN: A,NOP,B then request -> replay A,B only (count=2).
//   Without the macro: replay A,NOP,B (count=3).

Source files
------------

// File: rtl/qed_pkg.sv
// Shared definitions for the QED instruction cache / replay stage.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package qed_pkg;

    // RISC-V canonical NOP (addi x0, x0, 0); also the idle value of the replay output.
    localparam logic [31:0] QED_NOP = 32'h0000_0013;

    typedef enum logic {
        QIC_ORIG = 1'b0,
        QIC_DUP  = 1'b1
    } qed_ic_mode_t;

    function automatic int qic_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/qed_ic_ram.sv
// DEPTH x WIDTH instruction store: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller gates wr_en. Contents are not reset.
// Ports: clk, wr_en/wr_addr/wr_dat (write), rd_addr/rd_dat (read).
module qed_ic_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/qed_dup_replay_buffer.sv
// QED replay stage: passes and records fetched instructions (ORIG), then replays them in order (DUP).
// Latency: one cycle from ifu_instruction / buffer read to qic_qimux_instruction.
// Backpressure: qic_fetch_hold asks fetch to hold PC during DUP or when the buffer is full; stall freezes everything.
// Ports: clk, rst_n (sync, active-low), qed_ena, stall, ifu_instruction/ifu_vld, exec_dup_req in;
//        qic_qimux_instruction/qic_vld, qed_exec_dup, qic_fetch_hold, qic_count out.
// Option: define QED_IC_NOP_FILTER_EN to pass NOPs through without recording them.
module qed_dup_replay_buffer
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       qed_ena,
    input  logic                       stall,
    input  logic [WIDTH-1:0]           ifu_instruction,
    input  logic                       ifu_vld,
    input  logic                       exec_dup_req,
    output logic [WIDTH-1:0]           qic_qimux_instruction,
    output logic                       qic_vld,
    output logic                       qed_exec_dup,
    output logic                       qic_fetch_hold,
    output logic [$clog2(DEPTH):0]     qic_count
);

    localparam int PTR_W = qic_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] NOP_W   = WIDTH'(QED_NOP);

    qed_ic_mode_t     mode;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] rd_dat;
    logic             keep;
    logic             rec_en;
    logic             go_dup;
    logic             last_rep;
    logic [CNT_W-1:0] count_nxt;

`ifdef QED_IC_NOP_FILTER_EN
    assign keep = (ifu_instruction != NOP_W);
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        rec_en    = (mode == QIC_ORIG) && !stall && ifu_vld && qed_ena
                    && (qic_count < DEPTH_C) && keep;
        count_nxt = qic_count + CNT_W'(rec_en);
        // The entry decision sees the count including an instruction recorded on this same edge.
        go_dup    = (mode == QIC_ORIG) && !stall && qed_ena
                    && (exec_dup_req || (count_nxt == DEPTH_C)) && (count_nxt != '0);
        last_rep  = ({1'b0, rd_ptr} == (qic_count - 1'b1));
    end

    assign qic_fetch_hold = (mode == QIC_DUP) || (qic_count == DEPTH_C);

    qed_ic_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (rec_en),
        .wr_addr (wr_ptr),
        .wr_dat  (ifu_instruction),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode                  <= QIC_ORIG;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            qic_count             <= '0;
            qic_qimux_instruction <= NOP_W;
            qic_vld               <= 1'b0;
            qed_exec_dup          <= 1'b0;
        end else if (!stall) begin
            if (mode == QIC_ORIG) begin
                qed_exec_dup <= 1'b0;
                if (ifu_vld) begin
                    qic_qimux_instruction <= ifu_instruction;
                    qic_vld               <= 1'b1;
                end else begin
                    qic_qimux_instruction <= NOP_W;
                    qic_vld               <= 1'b0;
                end
                if (rec_en) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    qic_count <= count_nxt;
                end
                if (go_dup) begin
                    mode <= QIC_DUP;
                end
            end else begin
                // Replay runs to completion regardless of qed_ena; fetch input is ignored.
                qic_qimux_instruction <= rd_dat;
                qic_vld               <= 1'b1;
                qed_exec_dup          <= 1'b1;
                if (last_rep) begin
                    mode      <= QIC_ORIG;
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    qic_count <= '0;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule
